// File: rtl/barrel_shifter_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROL/ROR) for the ALU shift path.
// Right-going modes are bit-reversed on entry and exit so a single left-shift core serves every mode.
module barrel_shifter_pipe #(
  parameter int DATA_W        = 32,
  parameter int SHAMT_W       = $clog2(DATA_W),
  parameter int LVL_PER_STAGE = 2
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic [SHAMT_W-1:0] in_shamt_i,
  input  logic [2:0]         in_mode_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               out_err_o
);

  localparam int DEPTH = (SHAMT_W + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  // One mux level: the low half of the concatenation supplies either wrap bits or fill bits.
  function automatic logic [DATA_W-1:0] shl_lvl(input logic [DATA_W-1:0] d, input int amt,
                                                input logic rot, input logic fill);
    logic [2*DATA_W-1:0] t;
    t = {d, (rot ? d : {DATA_W{fill}})} << amt;
    return t[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic is_right(input logic [2:0] m);
    return (m == MODE_SRL) || (m == MODE_SRA) || (m == MODE_ROR);
  endfunction

  function automatic logic is_rot(input logic [2:0] m);
    return (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

  logic               stall;
  logic               advance;
  logic               front_legal;
  logic [DATA_W-1:0]  front_data;
  logic [SHAMT_W-1:0] front_shamt;
  logic               front_fill;

  always_comb begin
    front_legal = (in_mode_i == MODE_SLL) || (in_mode_i == MODE_ROL) || is_right(in_mode_i);
    front_data  = is_right(in_mode_i) ? bit_rev(in_data_i) : in_data_i;
    front_shamt = front_legal ? in_shamt_i : '0;
    front_fill  = (in_mode_i == MODE_SRA) && in_data_i[DATA_W-1];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : stg
    localparam int LO = k * LVL_PER_STAGE;
    localparam int HI = ((k + 1) * LVL_PER_STAGE > SHAMT_W) ? SHAMT_W : (k + 1) * LVL_PER_STAGE;
    localparam bit LAST = (k == DEPTH - 1);

    logic [DATA_W-1:0]   src_data;
    logic [SHAMT_W-1:LO] src_shamt;
    logic [2:0]          src_mode;
    logic                src_fill;
    logic                src_err;
    logic                src_vld;
    logic [DATA_W-1:0]   nxt_data;
    logic [DATA_W-1:0]   data;
    logic                err;
    logic                vld;

    if (k == 0) begin : g_src
      assign src_data  = front_data;
      assign src_shamt = front_shamt;
      assign src_mode  = in_mode_i;
      assign src_fill  = front_fill;
      assign src_err   = ~front_legal;
      assign src_vld   = in_valid_i;
    end else begin : g_src
      assign src_data  = stg[k-1].data;
      assign src_shamt = stg[k-1].g_carry.shamt;
      assign src_mode  = stg[k-1].g_carry.mode;
      assign src_fill  = stg[k-1].g_carry.fill;
      assign src_err   = stg[k-1].err;
      assign src_vld   = stg[k-1].vld;
    end

    always_comb begin
      nxt_data = src_data;
      for (int j = LO; j < HI; j++)
        if (src_shamt[j]) nxt_data = shl_lvl(nxt_data, 1 << j, is_rot(src_mode), src_fill);
      if (LAST && is_right(src_mode)) nxt_data = bit_rev(nxt_data);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)      vld <= 1'b0;
      else if (flush_i) vld <= 1'b0;
      else if (advance) vld <= src_vld;
    end

    // Output stage is architecturally visible and must read zero out of reset.
    if (LAST) begin : g_out
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          data <= '0;
          err  <= 1'b0;
        end else if (advance) begin
          data <= nxt_data;
          err  <= src_err;
        end
      end
    end else begin : g_carry
      logic [SHAMT_W-1:HI] shamt;
      logic [2:0]          mode;
      logic                fill;

      always_ff @(posedge clk_i) begin
        if (advance) begin
          data  <= nxt_data;
          err   <= src_err;
          shamt <= src_shamt[SHAMT_W-1:HI];
          mode  <= src_mode;
          fill  <= src_fill;
        end
      end
    end
  end

  assign out_valid_o = stg[DEPTH-1].vld;
  assign out_data_o  = stg[DEPTH-1].data;
  assign out_err_o   = stg[DEPTH-1].err;

  // Whole pipe stalls as one unit; bubbles are deliberately not squeezed out.
  assign stall      = out_valid_o & ~out_ready_i;
  assign advance    = ~stall;
  assign in_ready_o = advance;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: directed vector table, handshake/flush/reset
// sequences and a randomized stream scored against a queue-based arithmetic reference model.
module tb_barrel_shifter_pipe;

  localparam int W     = 32;
  localparam int SW    = 5;
  localparam int LVL   = 2;
  localparam int DEPTH = (SW + LVL - 1) / LVL;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [2:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_err;

  barrel_shifter_pipe #(.DATA_W(W), .SHAMT_W(SW), .LVL_PER_STAGE(LVL)) dut (
    .clk_i      (clk),
    .rstn_i     (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_shamt_i (in_shamt),
    .in_mode_i  (in_mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_err_o  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [W:0] hold_val;
  logic       accepted;
  int         n_acc = 0;
  int         n_del = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain shift/rotate arithmetic, {err, data}.
  function automatic logic [W:0] model(input logic [W-1:0] d, input int s, input logic [2:0] m);
    logic [W-1:0] r;
    logic         e;
    e = 1'b0;
    case (m)
      3'd0:    r = d << s;
      3'd1:    r = d >> s;
      3'd2:    r = $signed(d) >>> s;
      3'd3:    r = (d << s) | (d >> (W - s));
      3'd4:    r = (d >> s) | (d << (W - s));
      default: begin r = d; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // Called at the falling edge: decides what the next rising edge will transfer.
  task automatic monitor();
    logic [W:0] e;
    accepted = 1'b0;
    if (!rst_n) begin
      hold_pending = 1'b0;
      return;
    end
    if (hold_pending) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_err, out_data}, hold_val);
    end
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    hold_pending = out_valid && !out_ready && !flush;
    hold_val     = {out_err, out_data};
    if (out_valid && out_ready) begin
      n_del++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected no result", {out_err, out_data});
      end else begin
        e = exp_q.pop_front();
        chk("stream_result", {out_err, out_data}, e);
      end
    end
    if (flush) exp_q.delete();
    if (in_valid && in_ready && !flush) begin
      exp_q.push_back(model(in_data, int'(in_shamt), in_mode));
      accepted = 1'b1;
      n_acc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic [2:0]    m;
    logic [W-1:0]  ed;
    logic          ee;
  } vec_t;

  vec_t tbl[17];
  int   pat[4];

  initial begin
    int lat;
    int sent;
    int cyc;
    int a0;
    int d0;
    int r;

    tbl[0]  = '{32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 1'b0};
    tbl[1]  = '{32'h8000_0000, 5'd4,  3'd2, 32'hF800_0000, 1'b0};
    tbl[2]  = '{32'h8000_0000, 5'd4,  3'd1, 32'h0800_0000, 1'b0};
    tbl[3]  = '{32'h8000_0001, 5'd1,  3'd3, 32'h0000_0003, 1'b0};
    tbl[4]  = '{32'h0000_0003, 5'd1,  3'd4, 32'h8000_0001, 1'b0};
    tbl[5]  = '{32'h1234_5678, 5'd7,  3'd6, 32'h1234_5678, 1'b1};
    tbl[6]  = '{32'hDEAD_BEEF, 5'd0,  3'd2, 32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{32'hDEAD_BEEF, 5'd0,  3'd4, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{32'hDEAD_BEEF, 5'd0,  3'd0, 32'hDEAD_BEEF, 1'b0};
    tbl[9]  = '{32'h7000_0000, 5'd31, 3'd2, 32'h0000_0000, 1'b0};
    tbl[10] = '{32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, 1'b0};
    tbl[11] = '{32'h1234_5678, 5'd8,  3'd3, 32'h3456_7812, 1'b0};
    tbl[12] = '{32'h1234_5678, 5'd4,  3'd4, 32'h8123_4567, 1'b0};
    tbl[13] = '{32'hFFFF_FFFF, 5'd31, 3'd1, 32'h0000_0001, 1'b0};
    tbl[14] = '{32'hA5A5_0F0F, 5'd3,  3'd5, 32'hA5A5_0F0F, 1'b1};
    tbl[15] = '{32'h0000_FFFF, 5'd16, 3'd0, 32'hFFFF_0000, 1'b0};
    tbl[16] = '{32'h8765_4321, 5'd31, 3'd4, 32'h0ECA_8643, 1'b0};
    pat = '{1, 0, 0, 1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_mode = '0;
    #12;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_err", out_err, 0);
    chk("reset_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();

    // Directed vectors, one at a time, with latency measured from the accepting edge.
    for (int i = 0; i < 17; i++) begin
      in_data = tbl[i].d; in_shamt = tbl[i].s; in_mode = tbl[i].m;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk($sformatf("tbl%0d_accept", i), accepted, 1);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("tbl%0d_latency", i), lat, DEPTH - 1);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_err", i), out_err, tbl[i].ee);
      tick();
    end

    // Back-to-back 8 ops, out_ready toggling 1,0,0,1.
    d0 = n_del; sent = 0; cyc = 0;
    in_data = $urandom; in_shamt = SW'($urandom_range(0, W - 1)); in_mode = 3'd0;
    while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
      out_ready = (pat[cyc % 4] != 0);
      in_valid  = (sent < 8);
      tick();
      if (accepted) begin
        sent++;
        in_data = $urandom; in_shamt = SW'($urandom_range(0, W - 1)); in_mode = 3'(sent % 5);
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("b2b_sent", sent, 8);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_delivered", n_del - d0, 8);

    // Flush with three operations in flight (output held stalled first).
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h1111_1111 * (i + 1); in_shamt = 5'(i + 1); in_mode = 3'd0; in_valid = 1'b1;
      tick();
      chk($sformatf("flush_acc%0d", i), accepted, 1);
    end
    in_valid = 1'b0;
    chk("flush_pre_valid", out_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("flush_no_valid%0d", i), out_valid, 0);
      tick();
    end
    // Input offered in the flush cycle is discarded.
    in_data = 32'hCAFE_F00D; in_shamt = 5'd3; in_mode = 3'd3; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("flush_in_drop%0d", i), out_valid, 0);
      tick();
    end

    // Randomized stream against the reference model.
    a0 = n_acc; cyc = 0;
    while (n_acc - a0 < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = $urandom;
      in_shamt  = SW'($urandom_range(0, W - 1));
      r         = $urandom_range(0, 15);
      in_mode   = (r < 13) ? 3'(r % 5) : 3'(r - 8);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 199) == 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    chk("rand_count", (n_acc - a0) >= 10000, 1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("rand_drain", exp_q.size(), 0);
    tick();
    chk("rand_idle_valid", out_valid, 0);

    // Asynchronous reset mid-stream drops everything at once.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h8000_0000 >> i; in_shamt = 5'd2; in_mode = 3'd2; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_data", out_data, 0);
    chk("mid_reset_err", out_err, 0);
    exp_q.delete();
    hold_pending = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_reset_valid%0d", i), out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
